// File: rtl/sqrt_iter_pkg.sv
// Shared types and width helpers for the iterative square-root block.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // The root has half as many bits as the radicand.
    function automatic int out_width(input int in_w);
        return in_w / 2;
    endfunction

    // The iteration counter must be able to count up to OUT_W.
    function automatic int cnt_width(input int out_w);
        return $clog2(out_w + 1);
    endfunction

endpackage

// File: rtl/sqrt_iter_step.sv
// One restoring digit-by-digit square-root iteration, purely combinational.
// Consumes two radicand bits and produces one more root bit.
module sqrt_step #(
    parameter int OUT_W = 16
) (
    input  logic [OUT_W+1:0] rem,
    input  logic [OUT_W-1:0] root,
    input  logic [1:0]       bits,
    output logic [OUT_W+1:0] rem_next,
    output logic [OUT_W-1:0] root_next
);

    localparam int REM_W  = OUT_W + 2;
    localparam int WIDE_W = OUT_W + 4;

    logic [WIDE_W-1:0] r_wide;
    logic [WIDE_W-1:0] t_wide;
    logic              take;

    // Trial-subtract (root<<2)|1 from the shifted remainder and keep the result if it does not go negative.
    always_comb begin
        r_wide    = {rem, bits};
        t_wide    = WIDE_W'({root, 2'b01});
        take      = (r_wide >= t_wide);
        rem_next  = REM_W'(r_wide);
        root_next = OUT_W'({root, 1'b0});
        if (take) begin
            rem_next  = REM_W'(r_wide - t_wide);
            root_next = OUT_W'({root, 1'b1});
        end
    end

endmodule

// File: rtl/sqrt_iter.sv
// Iterative integer square root: one root bit per clock, valid/ready on both sides.
// Returns floor(sqrt(x)) (optionally rounded to nearest) and the exact remainder.
module sqrt_iter
    import sqrt_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int ROUND = 0,
    localparam int OUT_W = out_width(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_root,
    output logic [OUT_W:0]   out_rem,
    output logic             busy
);

    localparam int REM_W  = OUT_W + 2;
    localparam int OREM_W = OUT_W + 1;
    localparam int CNT_W  = cnt_width(OUT_W);

    if (((IN_W % 2) != 0) || (IN_W < 4)) begin : g_bad_width
        $error("sqrt_iter: IN_W must be even and at least 4");
    end

    state_t             state_q;
    state_t             state_d;
    logic               ready_en;
    logic [IN_W-1:0]    radicand_q;
    logic [REM_W-1:0]   rem_q;
    logic [REM_W-1:0]   rem_next;
    logic [OUT_W-1:0]   root_q;
    logic [OUT_W-1:0]   root_next;
    logic [OUT_W-1:0]   root_final;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;
    logic               last_iter;
    logic               round_up;

    assign in_ready  = (state_q == IDLE) && ready_en;
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign last_iter = (cnt_q == CNT_W'(OUT_W - 1));

    sqrt_step #(
        .OUT_W(OUT_W)
    ) u_step (
        .rem       (rem_q),
        .root      (root_q),
        .bits      (radicand_q[IN_W-1 -: 2]),
        .rem_next  (rem_next),
        .root_next (root_next)
    );

    // Round to nearest when rem exceeds root, saturating at the all-ones root.
    always_comb begin
        round_up   = (rem_next > REM_W'(root_next));
        root_final = root_next;
        if ((ROUND != 0) && round_up && !(&root_next)) begin
            root_final = root_next + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, run OUT_W iterations, hold result until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)    state_d = CALC;
            CALC: if (last_iter) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Datapath: latch operand, iterate, and register the result on the last iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            radicand_q <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            cnt_q      <= '0;
            out_root   <= '0;
            out_rem    <= '0;
            out_valid  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        radicand_q <= in_data;
                        rem_q      <= '0;
                        root_q     <= '0;
                        cnt_q      <= '0;
                    end
                end
                CALC: begin
                    radicand_q <= {radicand_q[IN_W-3:0], 2'b00};
                    rem_q      <= rem_next;
                    root_q     <= root_next;
                    cnt_q      <= cnt_q + 1'b1;
                    if (last_iter) begin
                        out_root  <= root_final;
                        out_rem   <= OREM_W'(rem_next);
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_iter.sv
// Scoreboard bench for sqrt_iter: 32-bit and 8-bit channels, each with a truncating and a rounding instance.
module tb_sqrt_iter;

    typedef struct {
        longint data;
        longint root_t;
        longint root_r;
        longint rem;
        longint acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    // Channel A: IN_W=32
    logic        in_valid_a, out_ready_a;
    logic [31:0] in_data_a;
    logic        in_ready_a0, in_ready_a1, out_valid_a0, out_valid_a1, busy_a0, busy_a1;
    logic [15:0] root_a0, root_a1;
    logic [16:0] rem_a0, rem_a1;

    // Channel B: IN_W=8
    logic        in_valid_b, out_ready_b;
    logic [7:0]  in_data_b;
    logic        in_ready_b0, in_ready_b1, out_valid_b0, out_valid_b1, busy_b0, busy_b1;
    logic [3:0]  root_b0, root_b1;
    logic [4:0]  rem_b0, rem_b1;

    exp_t   q_a[$];
    exp_t   q_b[$];
    int     tests_run = 0;
    int     tests_failed = 0;
    longint cyc = 0;
    bit     ov_prev[2];
    longint last_rise[2];
    bit     space_check[2];
    bit     rand_ready_a = 0;
    bit     rand_ready_b = 0;

    sqrt_iter #(.IN_W(32), .ROUND(0)) dut_a0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a0), .in_data(in_data_a),
        .out_valid(out_valid_a0), .out_ready(out_ready_a), .out_root(root_a0), .out_rem(rem_a0), .busy(busy_a0));
    sqrt_iter #(.IN_W(32), .ROUND(1)) dut_a1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a1), .in_data(in_data_a),
        .out_valid(out_valid_a1), .out_ready(out_ready_a), .out_root(root_a1), .out_rem(rem_a1), .busy(busy_a1));
    sqrt_iter #(.IN_W(8), .ROUND(0)) dut_b0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b0), .in_data(in_data_b),
        .out_valid(out_valid_b0), .out_ready(out_ready_b), .out_root(root_b0), .out_rem(rem_b0), .busy(busy_b0));
    sqrt_iter #(.IN_W(8), .ROUND(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b1), .in_data(in_data_b),
        .out_valid(out_valid_b1), .out_ready(out_ready_b), .out_root(root_b1), .out_rem(rem_b1), .busy(busy_b1));

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used for latency and spacing measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Random consumer back-pressure when enabled.
    always @(posedge clk) begin
        #2;
        if (rand_ready_a) out_ready_a = 1'($urandom_range(0, 1));
        if (rand_ready_b) out_ready_b = 1'($urandom_range(0, 1));
    end

    task automatic check_output(input string name, input longint actual, input longint expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: largest r with r*r <= x; round up when sqrt(x) >= r + 1/2, i.e. (2r+1)^2 <= 4x.
    function automatic void ref_model(input longint x, input int out_w,
                                      output longint root_t, output longint root_r, output longint rem);
        longint lo, hi, mid, maxv;
        maxv = (longint'(1) << out_w) - 1;
        lo = 0;
        hi = maxv;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= x) lo = mid;
            else hi = mid - 1;
        end
        root_t = lo;
        rem    = x - lo * lo;
        root_r = ((2 * lo + 1) * (2 * lo + 1) <= 4 * x) ? lo + 1 : lo;
        if (root_r > maxv) root_r = maxv;
    endfunction

    // Offer one operand; the expected response is queued when the DUT is seen ready.
    task automatic apply_stimulus(input int ch, input longint x);
        exp_t e;
        bit   accepted;
        bit   rdy;
        ref_model(x, (ch == 0) ? 16 : 4, e.root_t, e.root_r, e.rem);
        e.data = x;
        if (ch == 0) begin in_valid_a = 1'b1; in_data_a = 32'(x); end
        else         begin in_valid_b = 1'b1; in_data_b = 8'(x);  end
        accepted = 0;
        for (int i = 0; i < 300 && !accepted; i++) begin
            @(negedge clk);
            rdy = (ch == 0) ? in_ready_a0 : in_ready_b0;
            if (rdy && rst_n) begin
                e.acc_cyc = cyc + 1;
                if (ch == 0) q_a.push_back(e); else q_b.push_back(e);
                accepted = 1;
            end
            @(posedge clk); #1;
        end
        if (ch == 0) in_valid_a = 1'b0; else in_valid_b = 1'b0;
        if (!accepted) check_output("accept timeout", 0, 1);
    endtask

    task automatic wait_valid(input int ch);
        bit seen;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (ch == 0) ? out_valid_a0 : out_valid_b0;
            if (!seen) begin @(posedge clk); #1; end
        end
        if (!seen) check_output("out_valid timeout", 0, 1);
    endtask

    task automatic drain(input int ch);
        for (int i = 0; i < 3000 && ((ch == 0) ? q_a.size() : q_b.size()) > 0; i++) @(posedge clk);
        #1;
        check_output("drain pending results", (ch == 0) ? q_a.size() : q_b.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag, input bit ir, input bit ov, input bit bz,
                                      input longint rt, input longint rm);
        check_output({tag, " in_ready"}, ir, 0);
        check_output({tag, " out_valid"}, ov, 0);
        check_output({tag, " busy"}, bz, 0);
        check_output({tag, " out_root"}, rt, 0);
        check_output({tag, " out_rem"}, rm, 0);
    endtask

    // Monitor: latency on every rising out_valid, result comparison on every output handshake.
    task automatic monitor_channel(input int ch, input bit ov0, input bit ov1, input bit bz0,
                                   input longint rt0, input longint rt1, input longint rm0, input longint rm1,
                                   input bit ordy, input int out_w);
        exp_t e;
        bit   have;
        if (!rst_n) begin
            ov_prev[ch] = 0;
            return;
        end
        have = 0;
        if (ch == 0) begin if (q_a.size() > 0) begin e = q_a[0]; have = 1; end end
        else         begin if (q_b.size() > 0) begin e = q_b[0]; have = 1; end end
        if (ov0 && !ov_prev[ch]) begin
            if (!have) check_output("out_valid with no operand pending", 1, 0);
            else       check_output("latency", cyc - e.acc_cyc, out_w);
            if (space_check[ch] && last_rise[ch] >= 0)
                check_output("result spacing", cyc - last_rise[ch], out_w + 2);
            last_rise[ch] = cyc;
        end
        if (ov0 && ordy) begin
            if (!have) begin
                check_output("handshake with no operand pending", 1, 0);
            end else begin
                if (ch == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
                check_output($sformatf("root trunc x=%0d", e.data), rt0, e.root_t);
                check_output($sformatf("root round x=%0d", e.data), rt1, e.root_r);
                check_output($sformatf("rem trunc x=%0d", e.data), rm0, e.rem);
                check_output($sformatf("rem round x=%0d", e.data), rm1, e.rem);
                check_output($sformatf("rem bound x=%0d", e.data), (rm0 <= 2 * rt0) ? 1 : 0, 1);
                check_output("round instance out_valid", ov1, 1);
                check_output("busy in DONE", bz0, 1);
            end
        end
        ov_prev[ch] = ov0;
    endtask

    // Sample both channels away from the active edge.
    always @(negedge clk) begin
        monitor_channel(0, out_valid_a0, out_valid_a1, busy_a0, root_a0, root_a1, rem_a0, rem_a1, out_ready_a, 16);
        monitor_channel(1, out_valid_b0, out_valid_b1, busy_b0, root_b0, root_b1, rem_b0, rem_b1, out_ready_b, 4);
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        longint exp_root, exp_round, exp_rem;
        rst_n = 1'b0;
        in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
        for (int c = 0; c < 2; c++) begin
            ov_prev[c] = 0; last_rise[c] = -1; space_check[c] = 0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset a0", in_ready_a0, out_valid_a0, busy_a0, root_a0, rem_a0);
        check_idle_outputs("reset a1", in_ready_a1, out_valid_a1, busy_a1, root_a1, rem_a1);
        check_idle_outputs("reset b0", in_ready_b0, out_valid_b0, busy_b0, root_b0, rem_b0);
        check_idle_outputs("reset b1", in_ready_b1, out_valid_b1, busy_b1, root_b1, rem_b1);

        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_output("in_ready before first edge after release", in_ready_a0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_output("in_ready after first edge a", in_ready_a0, 1);
        check_output("in_ready after first edge b", in_ready_b0, 1);
        @(posedge clk); #1;

        $display("[TB] directed 32-bit operands");
        apply_stimulus(0, 0);
        apply_stimulus(0, 1000000);
        apply_stimulus(0, 7);
        apply_stimulus(0, 6);
        apply_stimulus(0, 64'hFFFF_FFFF);
        drain(0);

        $display("[TB] random 32-bit operands with random back-pressure");
        rand_ready_a = 1;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) apply_stimulus(0, longint'($urandom_range(0, 2000)));
            else            apply_stimulus(0, longint'($urandom));
        end
        drain(0);
        rand_ready_a = 0;
        @(posedge clk); #1;

        $display("[TB] back-pressure hold");
        out_ready_a = 1'b0;
        ref_model(7, 16, exp_root, exp_round, exp_rem);
        apply_stimulus(0, 7);
        wait_valid(0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid_a = 1'b1;
            in_data_a  = $urandom;
            @(negedge clk);
            check_output("held out_valid", out_valid_a0, 1);
            check_output("held in_ready", in_ready_a0, 0);
            check_output("held busy", busy_a0, 1);
            check_output("held out_root", root_a0, exp_root);
            check_output("held out_rem", rem_a0, exp_rem);
        end
        @(posedge clk); #1;
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_output("in_ready after handshake", in_ready_a0, 1);
        check_output("out_valid after handshake", out_valid_a0, 0);
        @(posedge clk); #1;

        $display("[TB] reset during CALC");
        apply_stimulus(0, 1000);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q_a.delete();
        @(negedge clk);
        check_idle_outputs("mid-calc reset a0", in_ready_a0, out_valid_a0, busy_a0, root_a0, rem_a0);
        check_idle_outputs("mid-calc reset a1", in_ready_a1, out_valid_a1, busy_a1, root_a1, rem_a1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        apply_stimulus(0, 144);
        drain(0);

        $display("[TB] back-to-back with out_ready high");
        out_ready_a    = 1'b1;
        space_check[0] = 1;
        last_rise[0]   = -1;
        apply_stimulus(0, 4);
        apply_stimulus(0, 15);
        apply_stimulus(0, 16);
        drain(0);
        space_check[0] = 0;

        $display("[TB] 8-bit exhaustive sweep");
        rand_ready_b = 1;
        for (int x = 0; x < 256; x++) apply_stimulus(1, longint'(x));
        drain(1);
        rand_ready_b = 0;

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
